// File: rtl/sync_pkg.sv
// ============================================================================
// Module : sync_pkg
// Brief  : Shared state encodings, default widths and clog2 helper for the
//          sync_multi transmit-side blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] REL  = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_REQ  = REQ,
        ST_REL  = REL,
        ST_ACK  = ACK
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 64;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector: first set request bit at or
//          after the pointer, wrapping to bit 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               found_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_sel;

    // Prefer requests at or above the pointer; fall back to the lowest set bit.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_hi[i] = req_i[i] && (ID_W'(i) >= ptr_i);
        end
        w_sel   = (|w_hi) ? w_hi : req_i;
        found_o = |req_i;
        idx_o   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_tx_arbiter.sv
// ============================================================================
// Module : sync_tx_arbiter
// Brief  : Round-robin arbiter sharing one sync_multi crossing between
//          NUM_REQ requesters; drives the four-phase valid/done handshake.
//          Optional watchdog enabled by defining SYNC_TX_WATCHDOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_tx_arbiter
    import sync_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_W       = 2,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk_tx,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         sync_data,
    output logic                          sync_v,
    input  logic                          sync_d,
    output logic                          err
);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        gid_q, gid_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   v_q, v_d;
    logic                   busy_q, busy_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;

    logic                   w_found;
    logic [ID_W-1:0]        w_idx;
    logic [DATA_WIDTH-1:0]  w_word;
    logic [ID_W-1:0]        w_ptr_next;
    logic [NUM_REQ-1:0]     w_ack_hot;

`ifdef SYNC_TX_WATCHDOG_EN
    localparam int CNT_W = clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   w_expired;
    assign w_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic                   w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (w_found),
        .idx_o   (w_idx)
    );

    always_comb begin
        w_word    = '0;
        w_ack_hot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            w_ack_hot[i] = (gid_q == ID_W'(i));
        end
        w_ptr_next = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        v_d     = v_q;
        busy_d  = busy_q;
        ack_d   = '0;
`ifdef SYNC_TX_WATCHDOG_EN
        cnt_d   = cnt_q + CNT_W'(1);
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    data_d  = w_word;
                    gid_d   = w_idx;
                    v_d     = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_REQ;
`ifdef SYNC_TX_WATCHDOG_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_REQ: begin
                if (sync_d) begin
                    v_d     = 1'b0;
                    state_d = ST_REL;
`ifdef SYNC_TX_WATCHDOG_EN
                    cnt_d   = '0;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    v_d     = 1'b0;
                    busy_d  = 1'b0;
                    ptr_d   = w_ptr_next;
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_REL: begin
                if (!sync_d) begin
                    ack_d   = w_ack_hot;
                    state_d = ST_ACK;
`ifdef SYNC_TX_WATCHDOG_EN
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = w_ptr_next;
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_ACK: begin
                busy_d  = 1'b0;
                ptr_d   = w_ptr_next;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

`ifdef SYNC_TX_WATCHDOG_EN
    always_ff @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack       = ack_q;
    assign grant_id  = gid_q;
    assign busy      = busy_q;
    assign sync_data = data_q;
    assign sync_v    = v_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_tx_arbiter.sv
// ============================================================================
// Module : tb_sync_tx_arbiter
// Brief  : Scoreboard bench for sync_tx_arbiter with a 3-cycle crossing model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_tx_arbiter;

    logic        clk_tx;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  sync_data;
    logic        sync_v;
    logic        sync_d;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   rem[4];
    logic [3:0] prev_ack;
    int   xcnt;

    sync_tx_arbiter dut (
        .clk_tx    (clk_tx),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .sync_data (sync_data),
        .sync_v    (sync_v),
        .sync_d    (sync_d),
        .err       (err)
    );

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    // Crossing model: done follows valid up and down with a 3-cycle delay.
    always @(posedge clk_tx or negedge reset) begin
        if (!reset) begin
            sync_d <= 1'b0;
            xcnt   <= 0;
        end else if (sync_v != sync_d) begin
            if (xcnt == 2) begin
                sync_d <= sync_v;
                xcnt   <= 0;
            end else begin
                xcnt <= xcnt + 1;
            end
        end else begin
            xcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every ack pulse is matched against the head of the scoreboard.
    initial prev_ack = '0;
    always @(negedge clk_tx) begin
        if (prev_ack != 4'b0) chk("ack_one_cycle", {28'b0, ack}, 32'h0);
        if (ack != 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", {28'b0, ack}, 32'h0);
            end else begin
                m_e = exp_q.pop_front();
                chk("ack_onehot", {28'b0, ack}, 32'h1 << m_e.id);
                chk("ack_grant_id", {30'b0, grant_id}, {30'b0, m_e.id});
                chk("ack_sync_data", {24'b0, sync_data}, {24'b0, m_e.data});
            end
        end
        prev_ack = ack;
    end

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic set_word(input int i, input logic [7:0] d);
        req_data[i*8 +: 8] = d;
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || req != 4'b0) && n < budget) begin
            @(negedge clk_tx);
            n++;
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    if (rem[i] > 0) rem[i]--;
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
        if (n >= budget) chk("run_timeout", 32'h1, 32'h0);
    endtask

    task automatic wait_v(input logic lvl, input int budget);
        int n = 0;
        while (sync_v !== lvl && n < budget) begin
            @(negedge clk_tx);
            n++;
        end
        if (n >= budget) chk("wait_sync_v_timeout", 32'h1, 32'h0);
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        repeat (3) @(negedge clk_tx);
        chk("rst_sync_v",    {31'b0, sync_v},    32'h0);
        chk("rst_sync_data", {24'b0, sync_data}, 32'h0);
        chk("rst_ack",       {28'b0, ack},       32'h0);
        chk("rst_busy",      {31'b0, busy},      32'h0);
        chk("rst_grant_id",  {30'b0, grant_id},  32'h0);
        chk("rst_err",       {31'b0, err},       32'h0);
        reset = 1'b1;
        @(negedge clk_tx);

        // Single request, one-cycle grant latency.
        set_word(1, 8'hA5);
        push(1, 8'hA5);
        rem[1] = 1;
        req = 4'b0010;
        @(negedge clk_tx);
        chk("lat_sync_v",    {31'b0, sync_v},    32'h1);
        chk("lat_sync_data", {24'b0, sync_data}, 32'hA5);
        chk("lat_grant_id",  {30'b0, grant_id},  32'h1);
        chk("lat_busy",      {31'b0, busy},      32'h1);
        run(100);
        chk("busy_after_ack", {31'b0, busy}, 32'h0);

        // All four requesting from pointer 0: 0,1,2,3,0.
        reset = 1'b0;
        @(negedge clk_tx);
        reset = 1'b1;
        set_word(0, 8'h11);
        set_word(1, 8'h22);
        set_word(2, 8'h33);
        set_word(3, 8'h44);
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
        req = 4'b1111;
        run(400);

        // Pointer wrap: move pointer to 3, then req=1001 grants 3 before 0.
        set_word(2, 8'h77);
        push(2, 8'h77);
        rem[2] = 1;
        req = 4'b0100;
        run(100);
        set_word(3, 8'h99);
        set_word(0, 8'h88);
        push(3, 8'h99); push(0, 8'h88);
        rem[3] = 1; rem[0] = 1;
        req = 4'b1001;
        run(200);

        // Reset in REQ aborts immediately; held request is re-granted after release.
        set_word(2, 8'hC3);
        rem[2] = 1;
        req = 4'b0100;
        wait_v(1'b1, 20);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_sync_v", {31'b0, sync_v}, 32'h0);
        chk("async_rst_busy",   {31'b0, busy},   32'h0);
        chk("async_rst_ack",    {28'b0, ack},    32'h0);
        repeat (2) @(negedge clk_tx);
        push(2, 8'hC3);
        reset = 1'b1;
        @(negedge clk_tx);
        chk("post_rst_sync_v",   {31'b0, sync_v},   32'h1);
        chk("post_rst_grant_id", {30'b0, grant_id}, 32'h2);
        run(100);

        // Requester drops req during REL: ack still pulses, no re-grant.
        set_word(0, 8'h5A);
        push(0, 8'h5A);
        rem[0] = 1;
        req = 4'b0001;
        wait_v(1'b1, 20);
        wait_v(1'b0, 20);
        req[0] = 1'b0;
        run(100);
        repeat (10) @(negedge clk_tx);
        chk("no_regrant", {30'b0, busy, sync_v}, 32'h0);
        chk("err_idle",   {31'b0, err},          32'h0);

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_tx_arbiter.md
Name: sync_tx_arbiter

Overview:
- Transmit-domain controller that shares one `sync_multi` clock-domain crossing between NUM_REQ requesters.
- Arbitrates round-robin, latches the winner's word, and drives the crossing's valid/data four-phase handshake.
- Waits for the crossing's done indication to rise and fall, then returns a one-cycle ack to the winning requester.
- Sits entirely in the clk_tx domain, directly in front of `sync_multi`.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 8: word width; must equal the `sync_multi` data width.
- ID_W, 2: grant index width, equal to clog2(NUM_REQ).
- TIMEOUT, 64: handshake watchdog limit in cycles. Used only with the optional feature.

Ports:
- clk_tx, in, 1: transmit clock; sole clock of the block.
- reset, in, 1: asynchronous, active-low reset.
- req, in, NUM_REQ: request bits. A requester holds its bit and its data stable until its ack.
- req_data, in, NUM_REQ*DATA_WIDTH: packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack, out, NUM_REQ: one-cycle completion pulse, one-hot.
- grant_id, out, ID_W: index of the current or last granted requester.
- busy, out, 1: high while a transfer is in flight.
- sync_data, out, DATA_WIDTH: word driven to the crossing; stable while sync_v is high.
- sync_v, out, 1: valid line to the crossing.
- sync_d, in, 1: done line from the crossing, already synchronised to clk_tx.
- err, out, 1: watchdog abort pulse. Tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: sync_v=0, sync_data=0, ack=0, busy=0, grant_id=0, err=0.
  - Internal: round-robin pointer=0, state=IDLE.
  - Asserting reset mid-transfer aborts at once; the crossing is reset by the same net.
- All outputs are registered.
- FSM states: IDLE, REQ, REL, ACK.
- IDLE:
  - If req has any bit set, select the first set bit at or after the pointer (wrapping).
  - Latch that requester's word into sync_data and its index into grant_id.
  - Set sync_v=1 and busy=1, then go to REQ.
  - sync_v is first high in the cycle after req is sampled: 1-cycle latency.
- REQ: hold sync_v and sync_data. When sync_d=1, set sync_v=0 and go to REL.
- REL: when sync_d=0, pulse ack[grant_id] for one cycle and go to ACK.
- ACK:
  - Clear ack and busy.
  - Set pointer = grant_id+1, wrapping NUM_REQ-1 to 0. Go to IDLE.
  - At most one new grant every 4+2·(crossing latency) cycles.
- sync_d already high on entry to REQ (stale): no special case; the transfer proceeds and REL waits for it to fall.
- Requester drops req mid-transfer: the transfer completes and ack still pulses.
- A requester whose ack is pulsing is not re-granted in that cycle; IDLE follows ACK.
- Simultaneous requests: the pointer guarantees each requester waits at most NUM_REQ-1 transfers.
- Data width rules: sync_data is an exact copy of the selected word; no arithmetic is performed on the data.

Optional Feature:
- Macro name: SYNC_TX_WATCHDOG_EN.
- With the macro defined:
  - A cycle counter of width clog2(TIMEOUT)+1 clears on entering REQ and on entering REL, and counts in both states.
  - At count TIMEOUT-1: err pulses for one cycle, sync_v=0, busy=0, no ack is issued, and the FSM goes to IDLE.
  - The pointer advances past the failed requester, which may re-request.
- Without the macro: no counter; REQ and REL wait indefinitely; err is constant 0.

Decomposition:
- Shared package `sync_pkg`:
  - State encoding localparams: IDLE=2'd0, REQ=2'd1, REL=2'd2, ACK=2'd3.
  - Default width constants for DATA_WIDTH and TIMEOUT.
  - A clog2 function.
- One sub-module, `rr_pick`:
  - Combinational round-robin selector.
  - Inputs: req and pointer. Outputs: a found flag and the granted index.
  - Reused by later multi-requester blocks.

Test Plan:
- Single request: req=4'b0010, data1=8'hA5, sync_d rises 3 cycles after sync_v and falls 3 cycles after sync_v drops → sync_data=A5 and grant_id=1 one cycle after req; ack=4'b0010 for exactly one cycle; busy low after ACK.
- All four requesting, data 11/22/33/44 → grants in order 0,1,2,3,0; each ack is one-hot; sync_data matches the granted word.
- Pointer wrap: pointer=3, req=4'b1001 → grant 3 first, then 0.
- Reset asserted while in REQ → sync_v, busy and ack go to 0 asynchronously, before the next clk_tx edge; after release, the pending req=4'b0100 is granted with grant_id=2.
- With SYNC_TX_WATCHDOG_EN and TIMEOUT=16, sync_d held at 0 → err pulses 16 cycles after sync_v rose; no ack; pointer advances.
- Requester drops req in REL → ack still pulses once; there is no second grant to it unless it re-requests.
